// File: rtl/dso_pkg.sv
// Shared types and constants for the capture-dump path of the scope controller.
package dso_pkg;

  localparam int ENTRIES_DEFAULT = 384;
  localparam logic [7:0] ERR_RESP = 8'hEE;
  localparam logic [1:0] DUMP_CH_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAT,
    ST_SEND,
    ST_WAIT,
    ST_ERR_SEND,
    ST_ERR_WAIT,
    ST_DONE
  } dump_state_t;

  // Successor of a circular-buffer address; n need not be a power of two.
  function automatic int wrap_next(input int a, input int n);
    return (a == n - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/wrap_addr_ctr.sv
// Loadable address counter that wraps from ENTRIES-1 back to 0.
module wrap_addr_ctr
  import dso_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT,
  parameter int AW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= AW'(wrap_next(int'(addr), ENTRIES));
    end
  end

endmodule

// File: rtl/dump_ctrl.sv
// Streams one captured channel, oldest sample first, out through the UART transmitter.
module dump_ctrl
  import dso_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT,
  parameter int AW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump,
  input  logic [1:0]    dump_ch,
  input  logic          capture_done,
  input  logic [AW-1:0] trace_end,
  input  logic [7:0]    ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd_en,
  output logic [1:0]    ram_ch,
  output logic [7:0]    tx_data,
  output logic          send_tx,
  input  logic          tx_done,
  output logic          busy,
  output logic          dump_done,
  output dump_state_t   dbg_state
);

  localparam int CW = AW + 1;

  // UART handshake: send_tx is a one-cycle request with tx_data already stable;
  // tx_done is a one-cycle pulse honoured only in ST_WAIT / ST_ERR_WAIT.
  dump_state_t   state;
  logic [CW-1:0] cnt;
  logic          dump_ok;
  logic          accept;
  logic          reject;
  logic          ctr_inc;
  logic          last_byte;
  logic [AW-1:0] start_addr;

  assign dump_ok    = (dump_ch != DUMP_CH_RSVD) && capture_done;
  assign accept     = (state == ST_IDLE) && dump && dump_ok;
  assign reject     = (state == ST_IDLE) && dump && !dump_ok;
  assign start_addr = AW'(wrap_next(int'(trace_end), ENTRIES));
  assign ctr_inc    = (state == ST_WAIT) && tx_done;
  assign last_byte  = (cnt == CW'(ENTRIES - 1));
  assign dbg_state  = state;

  wrap_addr_ctr #(
    .ENTRIES(ENTRIES),
    .AW     (AW)
  ) u_addr_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(start_addr),
    .inc     (ctr_inc),
    .addr    (ram_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ram_rd_en <= 1'b0;
      ram_ch    <= '0;
      tx_data   <= '0;
      send_tx   <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      ram_rd_en <= 1'b0;
      send_tx   <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ram_ch    <= dump_ch;
            cnt       <= '0;
            ram_rd_en <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_RD;
          end else if (reject) begin
            tx_data <= ERR_RESP;
            send_tx <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_ERR_SEND;
          end
        end
        ST_RD: state <= ST_LAT;
        ST_LAT: begin
          tx_data <= ram_rdata;
          send_tx <= 1'b1;
          state   <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done) begin
            cnt <= cnt + CW'(1);
            if (last_byte) begin
              dump_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              ram_rd_en <= 1'b1;
              state     <= ST_RD;
            end
          end
        end
        ST_ERR_SEND: state <= ST_ERR_WAIT;
        ST_ERR_WAIT: begin
          if (tx_done) begin
            dump_done <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
